// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising RAM arbiter: access widths, FSM states and
// the requester that owns the in-flight access.
package mem_ctrl_pkg;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnMem
  } owner_e;

  // Encoding 2'b11 is treated as a word access.
  function automatic logic [2:0] width_bytes(input logic [1:0] width);
    case (width)
      MemByte: width_bytes = 3'd1;
      MemHalf: width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates a single byte-wide RAM port between instruction fetch and load/store,
// splitting 1/2/4-byte accesses into sequential little-endian byte cycles.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              stall_if_req,
  output logic              stall_mem_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_wr_c;
  logic [7:0]        ram_dout_c;
  logic [1:0]        lane;
  logic [31:0]       merged;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_addr_c  = base_q + ADDR_W'(cnt_q);
    ram_wr_c    = 1'b0;
    ram_dout_c  = 8'h00;

    // In READ, cnt_q counts bytes already addressed, so ram_din belongs to lane cnt_q-1.
    lane   = cnt_q[1:0] - 2'd1;
    merged = asm_q;
    merged[{lane, 3'b000} +: 8] = ram_din;

    unique case (state_q)
      StIdle: begin
        ram_addr_c = base_q;
        cnt_d      = 3'd0;
        if (mem_req && !mem_done_q) begin
          owner_d    = OwnMem;
          base_d     = mem_addr;
          nbytes_d   = width_bytes(mem_width);
          wdata_d    = mem_wdata;
          asm_d      = '0;
          cnt_d      = 3'd1;
          ram_addr_c = mem_addr;
          if (mem_we) begin
            ram_wr_c   = 1'b1;
            ram_dout_c = mem_wdata[7:0];
            if (width_bytes(mem_width) == 3'd1) begin
              mem_done_d = 1'b1;
              cnt_d      = 3'd0;
            end else begin
              state_d = StWrite;
            end
          end else begin
            state_d = StRead;
          end
        end else if (if_req && !if_cancel && !if_done_q) begin
          owner_d    = OwnIf;
          base_d     = if_addr;
          nbytes_d   = 3'd4;
          asm_d      = '0;
          cnt_d      = 3'd1;
          ram_addr_c = if_addr;
          state_d    = StRead;
        end
      end

      StRead: begin
        if (owner_q == OwnIf && if_cancel) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else if (cnt_q == nbytes_q) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
          if (owner_q == OwnIf) begin
            if_done_d = 1'b1;
            if_data_d = merged;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = merged;
          end
        end else begin
          asm_d = merged;
          cnt_d = cnt_q + 3'd1;
        end
      end

      StWrite: begin
        ram_wr_c   = 1'b1;
        ram_dout_c = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == nbytes_q - 3'd1) begin
          state_d    = StIdle;
          cnt_d      = 3'd0;
          mem_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM strobes are gated by reset so an interrupted store cannot write another byte.
  assign ram_addr      = reset ? '0    : ram_addr_c;
  assign ram_wr        = reset ? 1'b0  : ram_wr_c;
  assign ram_dout      = reset ? 8'h00 : ram_dout_c;
  assign if_done       = if_done_q;
  assign mem_done      = mem_done_q;
  assign if_data       = if_data_q;
  assign mem_rdata     = mem_rdata_q;
  assign stall_if_req  = if_req && !if_done_q;
  assign stall_mem_req = mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl against a byte RAM model with one-cycle read latency.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_cancel, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if_req, stall_mem_req;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  logic [7:0]  ram [0:65535];
  logic        tb_we;
  logic [15:0] tb_waddr;
  logic [7:0]  tb_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_cancel    (if_cancel),
    .if_data      (if_data),
    .if_done      (if_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_width    (mem_width),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .stall_if_req (stall_if_req),
    .stall_mem_req(stall_mem_req),
    .ram_addr     (ram_addr),
    .ram_wr       (ram_wr),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din)
  );

  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else if (ram_wr) ram[ram_addr[15:0]] <= ram_dout;
    ram_din <= ram[ram_addr[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  // Cycle 0 is the cycle in which the request is first presented.
  task automatic wait_done(input bit is_mem, output int cyc, output logic [31:0] data,
                           output int stall_n, output int wr_n);
    bit seen = 1'b0;
    cyc = -1; data = '0; stall_n = 0; wr_n = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ram_wr) wr_n++;
      if (is_mem ? stall_mem_req : stall_if_req) stall_n++;
      if (is_mem ? mem_done : if_done) begin
        seen = 1'b1;
        cyc  = c;
        data = is_mem ? mem_rdata : if_data;
      end
    end
    tick();
    if (is_mem) mem_req = 1'b0;
    else if_req = 1'b0;
  endtask

  task automatic mem_op(input logic we, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc, output logic [31:0] data,
                        output int wr_n);
    int stall_n;
    mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd; mem_req = 1'b1;
    wait_done(1'b1, cyc, data, stall_n, wr_n);
  endtask

  initial begin
    int          cyc, stall_n, wr_n, md, ifd, sif;
    logic [31:0] data, mdata, idata;

    reset = 1'b1; if_req = 0; if_addr = 0; if_cancel = 0; mem_req = 0; mem_we = 0;
    mem_width = 0; mem_addr = 0; mem_wdata = 0; tb_we = 0; tb_waddr = 0; tb_wdata = 0;
    poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00);
    poke(16'h1003, 8'h00);
    poke(16'h2000, 8'h78); poke(16'h2001, 8'h56); poke(16'h2002, 8'h34);
    poke(16'h2003, 8'h12);
    poke(16'h3000, 8'hDD); poke(16'h3001, 8'hCC); poke(16'h3002, 8'hBB);
    poke(16'h3003, 8'hAA);
    poke(16'h001F, 8'h55); poke(16'h0024, 8'h55);
    for (int i = 0; i < 4; i++) poke(16'h0040 + 16'(i), 8'h11);
    reset = 1'b0;
    @(negedge clk);
    check("rst_if_done",   {31'b0, if_done},  0);
    check("rst_mem_done",  {31'b0, mem_done}, 0);
    check("rst_if_data",   if_data,   0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_ram_wr",    {31'b0, ram_wr}, 0);
    check("rst_ram_addr",  ram_addr,  0);
    check("rst_ram_dout",  {24'b0, ram_dout}, 0);
    tick();

    // Word fetch
    if_addr = 32'h0000_1000; if_req = 1'b1;
    wait_done(1'b0, cyc, data, stall_n, wr_n);
    check("fetch_cyc",   cyc, 5);
    check("fetch_data",  data, 32'h0000_0513);
    check("fetch_stall", stall_n, 5);
    check("fetch_no_wr", wr_n, 0);

    // Store word, then read back at several widths
    mem_op(1'b1, 2'b10, 32'h20, 32'hDEAD_BEEF, cyc, data, wr_n);
    check("sw_cyc",  cyc, 4);
    check("sw_wr_n", wr_n, 4);
    check("sw_b0", {24'b0, ram[16'h20]}, 32'hEF);
    check("sw_b1", {24'b0, ram[16'h21]}, 32'hBE);
    check("sw_b2", {24'b0, ram[16'h22]}, 32'hAD);
    check("sw_b3", {24'b0, ram[16'h23]}, 32'hDE);
    check("sw_lo_guard", {24'b0, ram[16'h1F]}, 32'h55);
    check("sw_hi_guard", {24'b0, ram[16'h24]}, 32'h55);
    mem_op(1'b0, 2'b10, 32'h20, 32'h0, cyc, data, wr_n);
    check("lw_cyc",  cyc, 5);
    check("lw_data", data, 32'hDEAD_BEEF);
    check("lw_no_wr", wr_n, 0);
    mem_op(1'b0, 2'b00, 32'h21, 32'h0, cyc, data, wr_n);
    check("lb_cyc",  cyc, 2);
    check("lb_data", data, 32'h0000_00BE);
    mem_op(1'b0, 2'b01, 32'h23, 32'h0, cyc, data, wr_n);
    check("lh_misaligned_cyc",  cyc, 3);
    check("lh_misaligned_data", data, 32'h0000_55DE);
    mem_op(1'b0, 2'b11, 32'h1F, 32'h0, cyc, data, wr_n);
    check("w11_data", data, 32'hADBE_EF55);

    // Simultaneous requests: MEM first, IF stalled until its own completion
    if_addr = 32'h0000_2000; if_req = 1'b1;
    mem_we = 1'b0; mem_width = 2'b10; mem_addr = 32'h20; mem_req = 1'b1;
    md = -1; ifd = -1; sif = 0; mdata = '0; idata = '0;
    for (int c = 0; c < 30 && ifd < 0; c++) begin
      @(negedge clk);
      if (stall_if_req) sif++;
      if (mem_done && md < 0) begin md = c; mdata = mem_rdata; end
      if (if_done) begin ifd = c; idata = if_data; end
      tick();
      if (md == c) mem_req = 1'b0;
      if (ifd == c) if_req = 1'b0;
    end
    check("both_mem_cyc",  md, 5);
    check("both_mem_data", mdata, 32'hDEAD_BEEF);
    check("both_if_after", {31'b0, ifd > md}, 1);
    check("both_if_stall", sif, ifd);
    check("both_if_data",  idata, 32'h1234_5678);

    // Fetch cancelled in its third cycle, then redirected
    if_addr = 32'h0000_1000; if_req = 1'b1;
    @(negedge clk); check("cancel_c0_done", {31'b0, if_done}, 0);
    @(negedge clk); check("cancel_c1_done", {31'b0, if_done}, 0);
    tick(); if_cancel = 1'b1;
    @(negedge clk); check("cancel_c2_done", {31'b0, if_done}, 0);
    tick(); if_cancel = 1'b0; if_addr = 32'h0000_3000;
    @(negedge clk);
    check("cancel_c3_done", {31'b0, if_done}, 0);
    check("cancel_data_kept", if_data, 32'h1234_5678);
    @(posedge clk); #1;
    // The redirected fetch began in the previous cycle; its done pulse lands 4 cycles on.
    wait_done(1'b0, cyc, data, stall_n, wr_n);
    check("redirect_cyc",  cyc + 1, 5);
    check("redirect_data", data, 32'hAABB_CCDD);

    // Reset in the middle of a word store after two bytes
    mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hCAFE_F00D;
    mem_req = 1'b1;
    @(negedge clk); check("rststore_c0_wr", {31'b0, ram_wr}, 1);
    @(negedge clk); check("rststore_c1_wr", {31'b0, ram_wr}, 1);
    tick(); reset = 1'b1;
    @(negedge clk);
    check("rststore_c2_wr",   {31'b0, ram_wr}, 0);
    check("rststore_c2_done", {31'b0, mem_done}, 0);
    tick(); reset = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check("rststore_done",  {31'b0, mem_done}, 0);
    check("rststore_wr",    {31'b0, ram_wr}, 0);
    check("rststore_addr",  ram_addr, 0);
    check("rststore_ifd",   if_data, 0);
    check("rststore_mrd",   mem_rdata, 0);
    check("rststore_b0", {24'b0, ram[16'h40]}, 32'h0D);
    check("rststore_b1", {24'b0, ram[16'h41]}, 32'hF0);
    check("rststore_b2", {24'b0, ram[16'h42]}, 32'h11);
    check("rststore_b3", {24'b0, ram[16'h43]}, 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
